// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle controller: FSM states, opcode classes,
// opcode constants, datapath select encodings and the control-word bundle.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_I    = 3'd1,
    C_LW   = 3'd2,
    C_SW   = 3'd3,
    C_BR   = 3'd4,
    C_J    = 3'd5,
    C_HALT = 3'd6,
    C_ILL  = 3'd7
  } op_class_e;

  localparam logic [5:0] OP_LW   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100001;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_J    = 6'b110010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PC_PLUS1 = 2'b00;
  localparam logic [1:0] PC_ALU   = 2'b01;
  localparam logic [1:0] PC_JUMP  = 2'b10;

  typedef struct packed {
    logic       sel_ins;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_write;
    logic       mem_to_reg;
    logic       beq;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       retire;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/ctrl_op_decode.sv
// Combinational opcode classifier: maps the 6-bit opcode onto the
// instruction class the controller dispatches on.
module ctrl_op_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output op_class_e  op_class_o
);

  // Two top bits select the ALU classes; everything else is an exact match
  always_comb begin
    op_class_o = C_ILL;
    case (opcode_i[5:4])
      2'b00: op_class_o = C_R;
      2'b01: op_class_o = C_I;
      default: begin
        case (opcode_i)
          OP_LW:   op_class_o = C_LW;
          OP_SW:   op_class_o = C_SW;
          OP_BEQ:  op_class_o = C_BR;
          OP_BNE:  op_class_o = C_BR;
          OP_J:    op_class_o = C_J;
          OP_HALT: op_class_o = C_HALT;
          default: op_class_o = C_ILL;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// retired-instruction counter, sticky illegal-opcode flag and halt state.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             alu_flag,
  output logic             sel_ins,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             beq,
  output logic [1:0]       pc_src,
  output logic             pc_write,
  output logic             ir_write,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal,
  output logic             halted
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;
  op_class_e        op_class_s;
  ctrl_t            ctl_s, ctl_out_s;

  ctrl_op_decode u_op_decode (
    .opcode_i   (opcode),
    .op_class_o (op_class_s)
  );

  // Next-state and Moore output decode; only pc_write in BRANCH looks at alu_flag
  always_comb begin
    state_d = S_FETCH;
    ctl_s   = '0;
    ill_d   = ill_q;
    case (state_q)
      S_FETCH: begin
        ctl_s.ir_write = 1'b1;
        ctl_s.pc_write = 1'b1;
        ctl_s.pc_src   = PC_PLUS1;
        state_d        = S_DECODE;
      end
      S_DECODE: begin
        case (op_class_s)
          C_R:     state_d = S_EXEC_R;
          C_I:     state_d = S_EXEC_I;
          C_LW:    state_d = S_MEM_ADDR;
          C_SW:    state_d = S_MEM_ADDR;
          C_BR:    state_d = S_BRANCH;
          C_J:     state_d = S_JUMP;
          C_HALT:  state_d = S_HALT;
          default: begin
            state_d = S_FETCH;
            ill_d   = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_src_b = SRCB_REG;
        state_d         = S_WB_R;
      end
      S_WB_R: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_src_b = SRCB_REG;
        ctl_s.reg_dst   = 1'b1;
        ctl_s.reg_write = 1'b1;
        ctl_s.retire    = 1'b1;
        state_d         = S_FETCH;
      end
      S_EXEC_I: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_src_b = SRCB_IMM;
        state_d         = S_WB_I;
      end
      S_WB_I: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_src_b = SRCB_IMM;
        ctl_s.reg_write = 1'b1;
        ctl_s.retire    = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_src_b = SRCB_IMM;
        // An opcode that changed under us since DECODE falls back to FETCH
        if (op_class_s == C_LW) begin
          state_d = S_MEM_RD;
        end else if (op_class_s == C_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_RD: begin
        ctl_s.sel_ins = 1'b1;
        state_d       = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl_s.mem_to_reg = 1'b1;
        ctl_s.reg_write  = 1'b1;
        ctl_s.retire     = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_WR: begin
        ctl_s.sel_ins   = 1'b1;
        ctl_s.mem_write = 1'b1;
        ctl_s.retire    = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_src_b = SRCB_REG;
        ctl_s.beq       = opcode[0];
        ctl_s.pc_src    = PC_JUMP;
        ctl_s.pc_write  = alu_flag ^ opcode[0];
        ctl_s.retire    = 1'b1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        ctl_s.pc_src   = PC_JUMP;
        ctl_s.pc_write = 1'b1;
        ctl_s.retire   = 1'b1;
        state_d        = S_FETCH;
      end
      S_HALT: begin
        ctl_s.halted = 1'b1;
        state_d      = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Force every output low for as long as reset is held, not just after the edge
  always_comb begin
    ctl_out_s = '0;
    if (rst_n) begin
      ctl_out_s = ctl_s;
    end else begin
      ctl_out_s = '0;
    end
  end

  // Retirement counter next value, wrapping naturally at 2^CNT_W
  always_comb begin
    cnt_d = cnt_q;
    if (ctl_s.retire) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counter and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  assign sel_ins     = ctl_out_s.sel_ins;
  assign reg_write   = ctl_out_s.reg_write;
  assign reg_dst     = ctl_out_s.reg_dst;
  assign alu_src_a   = ctl_out_s.alu_src_a;
  assign alu_src_b   = ctl_out_s.alu_src_b;
  assign mem_write   = ctl_out_s.mem_write;
  assign mem_to_reg  = ctl_out_s.mem_to_reg;
  assign beq         = ctl_out_s.beq;
  assign pc_src      = ctl_out_s.pc_src;
  assign pc_write    = ctl_out_s.pc_write;
  assign ir_write    = ctl_out_s.ir_write;
  assign retire      = ctl_out_s.retire;
  assign halted      = ctl_out_s.halted;
  assign instr_count = cnt_q;
  assign illegal     = ill_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a 32-bit and a 4-bit-counter
// instance share stimulus; expected per-cycle outputs are queued by the driver.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       alu_flag = 1'b0;

  logic        a_sel_ins, a_reg_write, a_reg_dst, a_alu_src_a, a_mem_write, a_mem_to_reg, a_beq;
  logic        a_pc_write, a_ir_write, a_retire, a_illegal, a_halted;
  logic [1:0]  a_alu_src_b, a_pc_src;
  logic [31:0] a_cnt;
  logic        b_sel_ins, b_reg_write, b_reg_dst, b_alu_src_a, b_mem_write, b_mem_to_reg, b_beq;
  logic        b_pc_write, b_ir_write, b_retire, b_illegal, b_halted;
  logic [1:0]  b_alu_src_b, b_pc_src;
  logic [3:0]  b_cnt;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_flag(alu_flag),
    .sel_ins(a_sel_ins), .reg_write(a_reg_write), .reg_dst(a_reg_dst), .alu_src_a(a_alu_src_a),
    .alu_src_b(a_alu_src_b), .mem_write(a_mem_write), .mem_to_reg(a_mem_to_reg), .beq(a_beq),
    .pc_src(a_pc_src), .pc_write(a_pc_write), .ir_write(a_ir_write), .retire(a_retire),
    .instr_count(a_cnt), .illegal(a_illegal), .halted(a_halted)
  );

  multicycle_control #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_flag(alu_flag),
    .sel_ins(b_sel_ins), .reg_write(b_reg_write), .reg_dst(b_reg_dst), .alu_src_a(b_alu_src_a),
    .alu_src_b(b_alu_src_b), .mem_write(b_mem_write), .mem_to_reg(b_mem_to_reg), .beq(b_beq),
    .pc_src(b_pc_src), .pc_write(b_pc_write), .ir_write(b_ir_write), .retire(b_retire),
    .instr_count(b_cnt), .illegal(b_illegal), .halted(b_halted)
  );

  typedef struct packed {
    logic       sel_ins, reg_write, reg_dst, alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_write, mem_to_reg, beq;
    logic [1:0] pc_src;
    logic       pc_write, ir_write, retire, illegal, halted;
  } obs_t;

  typedef struct packed {
    obs_t        o;
    logic [31:0] cnt;
  } exp_t;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_HALT, K_ILL} kind_e;

  obs_t act_a, act_b;
  assign act_a = {a_sel_ins, a_reg_write, a_reg_dst, a_alu_src_a, a_alu_src_b, a_mem_write,
                  a_mem_to_reg, a_beq, a_pc_src, a_pc_write, a_ir_write, a_retire, a_illegal, a_halted};
  assign act_b = {b_sel_ins, b_reg_write, b_reg_dst, b_alu_src_a, b_alu_src_b, b_mem_write,
                  b_mem_to_reg, b_beq, b_pc_src, b_pc_write, b_ir_write, b_retire, b_illegal, b_halted};

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail = 0;
  int          mon_cyc = 0;
  int unsigned m_cnt = 0;
  logic        m_ill = 1'b0;

  function automatic kind_e classify(input logic [5:0] op);
    if (op[5:4] == 2'b00) return K_R;
    if (op[5:4] == 2'b01) return K_I;
    case (op)
      6'b100000: return K_LW;
      6'b100001: return K_SW;
      6'b110000, 6'b110001: return K_BR;
      6'b110010: return K_J;
      6'b111111: return K_HALT;
      default:   return K_ILL;
    endcase
  endfunction

  // Monitor: every cycle with a queued expectation, compare both instances
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_cyc++;
      n_tests++;
      if (act_a !== mon_e.o) begin
        n_fail++;
        $display("FAIL ctl_a cyc=%0d got=%h exp=%h", mon_cyc, act_a, mon_e.o);
      end
      n_tests++;
      if (a_cnt !== mon_e.cnt) begin
        n_fail++;
        $display("FAIL count_a cyc=%0d got=%0d exp=%0d", mon_cyc, a_cnt, mon_e.cnt);
      end
      n_tests++;
      if (act_b !== mon_e.o) begin
        n_fail++;
        $display("FAIL ctl_b cyc=%0d got=%h exp=%h", mon_cyc, act_b, mon_e.o);
      end
      n_tests++;
      if (b_cnt !== mon_e.cnt[3:0]) begin
        n_fail++;
        $display("FAIL count_b cyc=%0d got=%0d exp=%0d", mon_cyc, b_cnt, mon_e.cnt[3:0]);
      end
    end
  end

  task automatic step(input logic [5:0] op, input logic flag, input obs_t o);
    exp_t e;
    opcode    = op;
    alu_flag  = flag;
    o.illegal = m_ill;
    e.o       = o;
    e.cnt     = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    obs_t z;
    z     = '0;
    rst_n = 1'b0;
    m_cnt = 0;
    m_ill = 1'b0;
    step(6'($urandom), 1'($urandom), z);
    step(6'($urandom), 1'($urandom), z);
    rst_n = 1'b1;
  endtask

  task automatic fetch_decode(input logic [5:0] op, input logic flag);
    obs_t v;
    v = '0;
    v.ir_write = 1'b1;
    v.pc_write = 1'b1;
    step(6'($urandom), 1'($urandom), v);
    v = '0;
    step(op, flag, v);
  endtask

  // Expected cycle sequence per instruction, built from the instruction's class
  task automatic run_instr(input logic [5:0] op, input logic flag);
    obs_t  v;
    kind_e k;
    k = classify(op);
    fetch_decode(op, flag);
    v = '0;
    case (k)
      K_R, K_I: begin
        v.alu_src_a = 1'b1;
        v.alu_src_b = (k == K_I) ? 2'b10 : 2'b00;
        step(op, flag, v);
        v.reg_write = 1'b1;
        v.reg_dst   = (k == K_R);
        v.retire    = 1'b1;
        step(op, flag, v);
        m_cnt++;
      end
      K_LW, K_SW: begin
        v.alu_src_a = 1'b1;
        v.alu_src_b = 2'b10;
        step(op, flag, v);
        v = '0;
        v.sel_ins = 1'b1;
        if (k == K_SW) begin
          v.mem_write = 1'b1;
          v.retire    = 1'b1;
          step(op, flag, v);
        end else begin
          step(op, flag, v);
          v = '0;
          v.mem_to_reg = 1'b1;
          v.reg_write  = 1'b1;
          v.retire     = 1'b1;
          step(op, flag, v);
        end
        m_cnt++;
      end
      K_BR: begin
        v.alu_src_a = 1'b1;
        v.beq       = op[0];
        v.pc_src    = 2'b10;
        v.pc_write  = (op == 6'b110000) ? flag : !flag;
        v.retire    = 1'b1;
        step(op, flag, v);
        m_cnt++;
      end
      K_J: begin
        v.pc_src   = 2'b10;
        v.pc_write = 1'b1;
        v.retire   = 1'b1;
        step(op, flag, v);
        m_cnt++;
      end
      K_HALT: begin
        v.halted = 1'b1;
        for (int i = 0; i < 20; i++) step(6'($urandom), 1'($urandom), v);
      end
      default: m_ill = 1'b1;
    endcase
  endtask

  initial begin
    logic [5:0] rop;
    obs_t       v;
    @(posedge clk);
    #1;
    apply_reset();
    run_instr(6'b000010, 1'b0);
    run_instr(6'b100000, 1'b1);
    run_instr(6'b100001, 1'b0);
    run_instr(6'b110000, 1'b1);
    run_instr(6'b110001, 1'b1);
    run_instr(6'b110000, 1'b0);
    run_instr(6'b110001, 1'b0);
    run_instr(6'b110010, 1'b0);
    run_instr(6'b010111, 1'b1);
    for (int i = 0; i < 60; i++) begin
      rop = 6'($urandom);
      if (rop == 6'b111111) rop = 6'b110010;
      run_instr(rop, 1'($urandom));
    end
    // Abort an R-type in its EXEC cycle with an asynchronous reset
    fetch_decode(6'b000011, 1'b0);
    apply_reset();
    for (int i = 0; i < 17; i++) run_instr(6'b110010, 1'($urandom));
    run_instr(6'b101111, 1'b0);
    run_instr(6'b000001, 1'b0);
    run_instr(6'b111111, 1'b0);
    v = '0;
    v.halted = 1'b1;
    step(6'b000000, 1'b1, v);
    @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
